vec_split: RTL and testbench

Unpacker for dense vector streams. It takes a stream of BUS_WIDTH-bit words in which VECTOR_WIDTH-bit vectors are concatenated back-to-back across word boundaries, with no padding. It re-emits each vector as ceil(VECTOR_WIDTH/BUS_WIDTH) bus words, starting each vector on a word boundary and zero-padding its final word. It sits on the receive side of the packed-vector link, between the input show-ahead FIFO and the per-vector processing units, and tags every output word with a vector ID.

---
 rtl/vec_pkg.sv | 19 +
 rtl/vec_split_if.sv | 26 ++
 rtl/vec_split_bit_gearbox.sv | 62 ++++++
 rtl/vec_split.sv | 81 ++++++++
 tb/tb_vec_split.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared sizing helpers for the vector unpacker: ceil-divide, words-per-vector, tail width.
// Pure constants and functions; no logic and no latency.
package vec_pkg;

    localparam int VEC_ID_WIDTH_DEF = 8;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int calc_w(input int vector_width, input int bus_width);
        return ceil_div(vector_width, bus_width);
    endfunction

    function automatic int calc_tail(input int vector_width, input int bus_width);
        return vector_width - (calc_w(vector_width, bus_width) - 1) * bus_width;
    endfunction

endpackage

// File: rtl/vec_split_if.sv
// Packed-stream input / word-aligned output bundle for vec_split.
// Input is show-ahead (popped by o_Read); output uses valid/ready.
interface vec_split_if #(
    parameter int BUS_WIDTH    = 128,
    parameter int VEC_ID_WIDTH = 8
);
    logic [BUS_WIDTH-1:0]    i_Vector;
    logic                    i_Valid;
    logic                    i_Last;
    logic                    o_Read;
    logic [BUS_WIDTH-1:0]    o_Vector;
    logic [VEC_ID_WIDTH-1:0] o_VecID;
    logic                    o_Valid;
    logic                    o_Last;
    logic                    i_Ready;

    modport slave (
        input  i_Vector, i_Valid, i_Last, i_Ready,
        output o_Read, o_Vector, o_VecID, o_Valid, o_Last
    );

    modport master (
        output i_Vector, i_Valid, i_Last, i_Ready,
        input  o_Read, o_Vector, o_VecID, o_Valid, o_Last
    );
endinterface

// File: rtl/vec_split_bit_gearbox.sv
// Residue buffer: appends input words above the fill, emits need bits from the bottom.
// Emit and accept share a cycle; the same-cycle emission is credited when checking space.
module bit_gearbox #(
    parameter  int BW   = 128,
    parameter  int TAIL = 24,
    localparam int CW   = $clog2(2*BW + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [BW-1:0] in_dat,
    input  logic          in_vld,
    input  logic          out_free,
    input  logic          is_tail,
    input  logic          last_seen,
    output logic          emit,
    output logic [BW-1:0] emit_dat,
    output logic          rd
);
    localparam logic [BW-1:0] TAIL_MASK = {BW{1'b1}} >> (BW - TAIL);

    logic [2*BW-1:0] rbuf;
    logic [2*BW-1:0] nxt_buf;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   nxt_cnt;
    logic [CW-1:0]   need;
    logic [CW-1:0]   used;
    logic [CW-1:0]   room_cnt;
    logic            flush;

    assign need     = is_tail ? CW'(TAIL) : CW'(BW);
    assign emit     = out_free && (cnt >= need);
    assign used     = emit ? need : '0;
    assign room_cnt = cnt - used;
    // last_seen doubles as "done": nothing of a following stream enters before o_Last
    assign rd       = rstn && in_vld && !last_seen && (room_cnt <= CW'(BW));
    assign emit_dat = rbuf[BW-1:0] & (is_tail ? TAIL_MASK : {BW{1'b1}});
    assign flush    = emit && is_tail && last_seen;

    // Bits above cnt are always zero, so the new word can simply be OR-ed in
    always_comb begin
        nxt_buf = rbuf >> used;
        nxt_cnt = room_cnt;
        if (rd) begin
            nxt_buf = nxt_buf | ({{BW{1'b0}}, in_dat} << room_cnt);
            nxt_cnt = room_cnt + CW'(BW);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rbuf <= '0;
            cnt  <= '0;
        end else if (flush) begin
            rbuf <= '0;
            cnt  <= '0;
        end else begin
            rbuf <= nxt_buf;
            cnt  <= nxt_cnt;
        end
    end

endmodule

// File: rtl/vec_split.sv
// Unpacks back-to-back VECTOR_WIDTH-bit vectors into word-aligned, zero-padded bus words tagged with a vector ID.
// One registered output stage (data seen the cycle after emission); stalls on !i_Ready, pops input only when space allows.
module vec_split
    import vec_pkg::*;
#(
    parameter int BUS_WIDTH    = 128,
    parameter int VECTOR_WIDTH = 920,
    parameter int VEC_ID_WIDTH = VEC_ID_WIDTH_DEF
) (
    input logic        clk,
    input logic        rstn,
    vec_split_if.slave vif
);
    localparam int W    = calc_w(VECTOR_WIDTH, BUS_WIDTH);
    localparam int TAIL = calc_tail(VECTOR_WIDTH, BUS_WIDTH);
    localparam int JW   = $clog2(W);

    logic [JW-1:0]           j;
    logic [VEC_ID_WIDTH-1:0] vec_id;
    logic                    last_seen;
    logic                    is_tail;
    logic                    out_free;
    logic                    emit;
    logic                    rd;
    logic [BUS_WIDTH-1:0]    emit_dat;

    assign is_tail    = (j == JW'(W - 1));
    assign out_free   = !vif.o_Valid || vif.i_Ready;
    assign vif.o_Read = rd;

    bit_gearbox #(
        .BW   (BUS_WIDTH),
        .TAIL (TAIL)
    ) u_gearbox (
        .clk       (clk),
        .rstn      (rstn),
        .in_dat    (vif.i_Vector),
        .in_vld    (vif.i_Valid),
        .out_free  (out_free),
        .is_tail   (is_tail),
        .last_seen (last_seen),
        .emit      (emit),
        .emit_dat  (emit_dat),
        .rd        (rd)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vif.o_Vector <= '0;
            vif.o_VecID  <= '0;
            vif.o_Valid  <= 1'b0;
            vif.o_Last   <= 1'b0;
            j            <= '0;
            vec_id       <= '0;
            last_seen    <= 1'b0;
        end else begin
            if (emit) begin
                vif.o_Vector <= emit_dat;
                vif.o_VecID  <= vec_id;
                vif.o_Valid  <= 1'b1;
                vif.o_Last   <= is_tail && last_seen;
                if (is_tail) begin
                    j      <= '0;
                    vec_id <= last_seen ? '0 : vec_id + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
                // Final tail: whatever is left in the buffer is stream padding
                if (is_tail && last_seen) begin
                    last_seen <= 1'b0;
                end
            end else if (vif.i_Ready) begin
                vif.o_Valid <= 1'b0;
            end
            if (rd && vif.i_Last) begin
                last_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_split.sv
// Directed bench for vec_split: dense streams, random ready/valid gaps, narrow ID, mid-stream reset.
module tb_vec_split;
    localparam int BW   = 128;
    localparam int VW   = 920;
    localparam int IDW  = 8;
    localparam int W    = 8;
    localparam int TAIL = 24;
    localparam int MAXV = 136;
    localparam int MAXW = (MAXV*VW + BW - 1) / BW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   rd_bad;
    int   hold_bad;

    logic [BW-1:0]  in_words [MAXW];
    logic [BW-1:0]  q_dat [$];
    logic [IDW-1:0] q_id [$];
    logic [2:0]     q_id3 [$];
    logic           q_last [$];

    always #5 clk = ~clk;

    vec_split_if #(.BUS_WIDTH(BW), .VEC_ID_WIDTH(IDW)) bus ();
    vec_split_if #(.BUS_WIDTH(BW), .VEC_ID_WIDTH(3))   bus3 ();

    assign bus3.i_Vector = bus.i_Vector;
    assign bus3.i_Valid  = bus.i_Valid;
    assign bus3.i_Last   = bus.i_Last;
    assign bus3.i_Ready  = bus.i_Ready;

    vec_split #(.BUS_WIDTH(BW), .VECTOR_WIDTH(VW), .VEC_ID_WIDTH(IDW)) dut (
        .clk (clk), .rstn (rstn), .vif (bus.slave)
    );

    vec_split #(.BUS_WIDTH(BW), .VECTOR_WIDTH(VW), .VEC_ID_WIDTH(3)) dut3 (
        .clk (clk), .rstn (rstn), .vif (bus3.slave)
    );

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference unpacking straight from the stream bit numbering
    function automatic logic [BW-1:0] ref_word(input int k, input int jj);
        logic [BW-1:0] r = '0;
        int lim = (jj == W-1) ? TAIL : BW;
        int n;
        for (int b = 0; b < lim; b++) begin
            n = k*VW + jj*BW + b;
            r[b] = in_words[n / BW][n % BW];
        end
        return r;
    endfunction

    task automatic fill_random(input int nw);
        for (int i = 0; i < nw; i++)
            in_words[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_stream(input int nvec, input bit gaps, input bit rdy_rand, input string tag);
        int nw   = (nvec*VW + BW - 1) / BW;
        int nout = nvec*W;
        bit drv_to = 1'b0;
        bit col_to = 1'b0;
        q_dat.delete(); q_id.delete(); q_id3.delete(); q_last.delete();
        rd_bad = 0;
        hold_bad = 0;
        fork
            begin : drv
                int i = 0;
                int cyc = 0;
                while (i < nw && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    if (gaps && $urandom_range(0, 2) == 0) begin
                        bus.i_Valid  = 1'b0;
                        bus.i_Last   = 1'b0;
                        bus.i_Vector = {$urandom, $urandom, $urandom, $urandom};
                    end else begin
                        bus.i_Valid  = 1'b1;
                        bus.i_Vector = in_words[i];
                        bus.i_Last   = (i == nw - 1);
                    end
                    #1;
                    if (bus.o_Read) begin
                        if (!bus.i_Valid) rd_bad++;
                        else i++;
                    end
                end
                if (i < nw) drv_to = 1'b1;
                @(negedge clk);
                bus.i_Valid = 1'b0;
                bus.i_Last  = 1'b0;
            end
            begin : col
                int got = 0;
                int cyc = 0;
                int left = 0;
                bit stall = 1'b0;
                logic [BW-1:0]  hv;
                logic [IDW-1:0] hid;
                logic           hl;
                bus.i_Ready = 1'b1;
                while (got < nout && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    if (stall && (bus.o_Valid !== 1'b1 || bus.o_Vector !== hv ||
                                  bus.o_VecID !== hid || bus.o_Last !== hl))
                        hold_bad++;
                    if (rdy_rand && left == 0) begin
                        if (bus.i_Ready) begin
                            left = $urandom_range(0, 5);
                            if (left != 0) bus.i_Ready = 1'b0;
                            else left = $urandom_range(1, 10);
                        end else begin
                            bus.i_Ready = 1'b1;
                            left = $urandom_range(1, 10);
                        end
                    end
                    if (left > 0) left--;
                    stall = bus.o_Valid && !bus.i_Ready;
                    hv  = bus.o_Vector;
                    hid = bus.o_VecID;
                    hl  = bus.o_Last;
                    if (bus.o_Valid && bus.i_Ready) begin
                        q_dat.push_back(bus.o_Vector);
                        q_id.push_back(bus.o_VecID);
                        q_id3.push_back(bus3.o_VecID);
                        q_last.push_back(bus.o_Last);
                        got++;
                    end
                end
                if (got < nout) col_to = 1'b1;
                bus.i_Ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check($sformatf("%s_drv_timeout", tag), BW'(drv_to), '0);
        check($sformatf("%s_col_timeout", tag), BW'(col_to), '0);
        check($sformatf("%s_extra_word", tag), BW'(bus.o_Valid), '0);
        check($sformatf("%s_count", tag), BW'(q_dat.size()), BW'(nout));
        check($sformatf("%s_read_no_valid", tag), BW'(rd_bad), '0);
        check($sformatf("%s_hold", tag), BW'(hold_bad), '0);
        for (int x = 0; x < q_dat.size() && x < nout; x++) begin
            check($sformatf("%s_dat%0d", tag, x), q_dat[x], ref_word(x / W, x % W));
            check($sformatf("%s_id%0d", tag, x), BW'(q_id[x]), BW'((x / W) % 256));
            check($sformatf("%s_id3_%0d", tag, x), BW'(q_id3[x]), BW'((x / W) % 8));
            check($sformatf("%s_last%0d", tag, x), BW'(q_last[x]), BW'(x == nout - 1));
        end
    endtask

    initial begin
        logic [BW-1:0] w7;
        logic [BW-1:0] w8;
        int acc;
        int cyc;

        // Reset state, with a word already presented
        bus.i_Vector = '1;
        bus.i_Valid  = 1'b1;
        bus.i_Last   = 1'b0;
        bus.i_Ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_vector", bus.o_Vector, '0);
        check("rst_vecid", BW'(bus.o_VecID), '0);
        check("rst_valid", BW'(bus.o_Valid), '0);
        check("rst_last", BW'(bus.o_Last), '0);
        check("rst_read", BW'(bus.o_Read), '0);
        bus.i_Valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);

        // Single vector: first seven words pass through, tail keeps in7[23:0]
        for (int i = 0; i < 8; i++)
            in_words[i] = {32'hC0DE_0000 | i, 32'hA5A5_0000 | i, 32'h0F0F_F0F0 ^ i, 32'h1234_5678 + i};
        run_stream(1, 1'b0, 1'b0, "v1");
        for (int i = 0; i < 7; i++)
            check($sformatf("v1_pass%0d", i), q_dat[i], in_words[i]);
        w7 = in_words[7];
        check("v1_tail", q_dat[7], {104'b0, w7[23:0]});

        // Two vectors: second vector starts at bit 24 of word 7
        fill_random(15);
        run_stream(2, 1'b0, 1'b0, "v2");
        w7 = in_words[7];
        w8 = in_words[8];
        check("v2_v1w0", q_dat[8], {w8[23:0], w7[127:24]});
        check("v2_v1id", BW'(q_id[8]), BW'(1));

        // Long random stream, random ready; then same stream with input gaps
        fill_random(MAXW);
        run_stream(MAXV, 1'b0, 1'b1, "rand");
        run_stream(MAXV, 1'b1, 1'b1, "gaps");

        // Reset in the middle of vector 3
        fill_random(40);
        bus.i_Ready = 1'b1;
        acc = 0;
        cyc = 0;
        while (acc < 27 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.i_Valid  = 1'b1;
            bus.i_Vector = in_words[acc];
            #1;
            if (bus.o_Read) acc++;
        end
        check("mid_accept_timeout", BW'(acc), BW'(27));
        @(negedge clk);
        check("mid_busy", BW'(bus.o_Valid), BW'(1));
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_vector", bus.o_Vector, '0);
        check("mid_rst_vecid", BW'(bus.o_VecID), '0);
        check("mid_rst_valid", BW'(bus.o_Valid), '0);
        check("mid_rst_last", BW'(bus.o_Last), '0);
        check("mid_rst_read", BW'(bus.o_Read), '0);
        @(negedge clk);
        bus.i_Valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        fill_random(30);
        run_stream(3, 1'b1, 1'b1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
